// File: rtl/mem_acc_pkg.sv
// mem_acc_pkg: size codes, FSM states and alignment check shared by the memory access unit.
package mem_acc_pkg;
  typedef enum logic [1:0] {SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10, SIZE_RSVD = 2'b11} size_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_RESP} state_e;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SIZE_HALF && off[0]) || (size == SIZE_WORD && off != 2'b00) || size == SIZE_RSVD;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane extract/extend for loads and lane merge for stores.
module mem_lane_align import mem_acc_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       size,
  input  logic             sgn,
  input  logic [1:0]       off,
  input  logic [WIDTH-1:0] word,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] store_word
);
  logic [4:0] sh;
  logic [WIDTH-1:0] shifted, mask;
  assign sh = {off, 3'b000};
  always_comb begin
    shifted = word >> sh;
    load_data = size == SIZE_BYTE ? {{24{sgn & shifted[7]}}, shifted[7:0]} :
                size == SIZE_HALF ? {{16{sgn & shifted[15]}}, shifted[15:0]} : word;
    mask = (size == SIZE_BYTE ? 32'h0000_00FF : size == SIZE_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF) << sh;
    store_word = (word & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine; sub-word stores run read-modify-write.
// Define MEM_ACC_RANGE_CHECK_EN to flag word indices >= MEM_DEPTH as errors.
module mem_access_unit import mem_acc_pkg::*; #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 63
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_w_data,
  output logic                  mem_w_en,
  output logic                  mem_r_en,
  input  logic [WIDTH-1:0]      mem_r_data
);
  state_e state, next;
  logic we_q, sgn_q, err_q, req_err;
  logic [1:0] size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q, wbuf_q, rdata_q, load_data, store_word;
`ifdef MEM_ACC_RANGE_CHECK_EN
  assign req_err = misaligned(req_size, req_addr[1:0]) || (req_addr >> 2) >= ADDR_WIDTH'(MEM_DEPTH);
`else
  assign req_err = misaligned(req_size, req_addr[1:0]);
`endif
  mem_lane_align #(.WIDTH(WIDTH)) u_align (
    .size(size_q), .sgn(sgn_q), .off(addr_q[1:0]), .word(mem_r_data),
    .wdata(wdata_q), .load_data(load_data), .store_word(store_word)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= ST_IDLE;
    else state <= next;
  always_comb begin
    next = state;
    unique case (state)
      ST_IDLE: if (req_valid) next = req_err ? ST_RESP : (req_we && req_size == SIZE_WORD) ? ST_WR : ST_RD;
      ST_RD:   next = we_q ? ST_WR : ST_RESP;
      ST_WR:   next = ST_RESP;
      ST_RESP: if (resp_ready) next = ST_IDLE;
    endcase
    req_ready = state == ST_IDLE;
    resp_valid = state == ST_RESP;
    mem_r_en = state == ST_RD;
    mem_w_en = state == ST_WR;
    mem_addr = (mem_r_en || mem_w_en) ? addr_q >> 2 : '0;
    mem_w_data = mem_w_en ? wbuf_q : '0;
    resp_rdata = resp_valid ? rdata_q : '0;
    resp_err = resp_valid & err_q;
  end
  // Word stores skip RD, so wbuf starts as the raw store data; RD overwrites it with the merged word.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      we_q <= 1'b0;
      sgn_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= 2'b00;
      addr_q <= '0;
      wdata_q <= '0;
      wbuf_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid) begin
          we_q <= req_we;
          sgn_q <= req_signed;
          err_q <= req_err;
          size_q <= req_size;
          addr_q <= req_addr;
          wdata_q <= req_wdata;
          wbuf_q <= req_wdata;
          rdata_q <= '0;
        end
        ST_RD: if (we_q) wbuf_q <= store_word;
               else rdata_q <= load_data;
        default: ;
      endcase
    end
endmodule
